id_ex_pipeline_reg: RTL
=======================

# id_ex_pipeline_reg

Pipeline register between decode and execute. Captures the decode-stage control word, including the ALU operation code from decode, register operands, immediates and register specifiers, and presents them to the execute stage one cycle later. Supports hold (stall), bubble insertion (flush) and trapping of undefined ALU operations. It sits directly downstream of the decode-stage ALU control logic and upstream of the ALU/forwarding muxes.

## Interface
- No parameters; widths fixed by the 32-bit MIPS datapath.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_e  in  1  hold current contents.
- flush_e  in  1  load a bubble.
- valid_d  in  1  decode stage holds a real instruction.
- alu_op_d  in  3  ALU operation code from decode (`ALU_OP_*` encodings).
- reg_write_d, mem_to_reg_d, mem_write_d, mem_byte_d, alu_src_d, reg_dst_d  in  1 each  decode control bits.
- rd1_d, rd2_d  in  32  register-file read data.
- sign_imm_d  in  32  sign/zero-extended immediate.
- rs_d, rt_d, rd_d, shamt_d  in  5 each  register specifiers and shift amount.
- Outputs: each `_d` input above has an `_e` counterpart of the same width, plus valid_e.
- illegal_e  out  1  registered instruction carried an undefined ALU op.

## Operation
- Update priority on each rising clk edge: rst > flush_e > stall_e > normal load.
- Normal load:
  - All `_e` outputs take their `_d` inputs.
  - illegal_e = valid_d & (alu_op_d == `ALU_OP_UNDEF`).
- Illegal trap: when illegal_e is loaded as 1, the register also forces reg_write_e, mem_write_e and mem_to_reg_e to 0. All other fields load normally.
- Stall: every output holds, including illegal_e.
- Flush loads a bubble:
  - valid_e = 0, all control bits = 0, alu_op_e = `ALU_OP_ADD`, illegal_e = 0.
  - rd1_e, rd2_e, sign_imm_e, rs_e, rt_e, rd_e and shamt_e = 0. Zeroed rs_e/rt_e keep the forwarding unit from matching.
- flush_e and stall_e high together: flush wins.
- valid_d = 0 on a normal load: the fields are loaded as presented. Decode guarantees zeroed control bits for invalid slots. illegal_e is 0.

## Timing
- Latency: exactly 1 cycle from `_d` inputs to `_e` outputs.
- There is no combinational path from input to output.
- Reset value of every output is the bubble value: all 0 except alu_op_e = `ALU_OP_ADD`.
- A reset asserted mid-stall clears contents on that edge. The stall is not honoured during rst.
- stall_e held N cycles keeps outputs constant for N cycles. The first edge after stall_e falls loads the current `_d` inputs.
- A single-cycle flush_e produces exactly one bubble cycle.

## Configuration
- Macro `ID_EX_PERF_COUNT_EN`.
- When defined, the block adds three outputs:
  - bubble_count  out  32  increments on each edge where flush_e = 1 and rst = 0.
  - stall_count  out  32  increments on each edge where stall_e = 1, flush_e = 0 and rst = 0.
  - illegal_count  out  32  increments on each edge where illegal_e is newly loaded as 1.
- All three counters reset to 0 and saturate at 32'hFFFF_FFFF; there is no wrap.
- When not defined, these ports and counters do not exist and area/behaviour are otherwise identical.

## Test plan
- Reset:
  - Stimulus: rst = 1 for 2 cycles with arbitrary `_d` inputs.
  - Required: all outputs 0, alu_op_e = `ALU_OP_ADD`, valid_e = 0; counters 0 if enabled.
- Normal load:
  - Stimulus: ADDU-type word (alu_op_d = `ALU_OP_ADD`, rd1_d = 32'h0000_0005, rd2_d = 32'h0000_0003, rd_d = 5'd8, reg_write_d = 1, valid_d = 1).
  - Required: exactly those values appear on the `_e` outputs one cycle later.
- Stall:
  - Stimulus: load a word with rd1_d = 32'hDEAD_BEEF, then stall_e = 1 for 3 cycles while `_d` inputs change.
  - Required: outputs stay at the first word for 3 cycles; the new word appears on the cycle after stall_e drops.
- Flush vs stall:
  - Stimulus: flush_e = 1 and stall_e = 1 in the same cycle while holding a valid word.
  - Required: next cycle valid_e = 0, reg_write_e = 0, rs_e = rt_e = 0, alu_op_e = `ALU_OP_ADD`.
- Illegal op:
  - Stimulus: valid_d = 1, alu_op_d = `ALU_OP_UNDEF`, reg_write_d = 1, mem_write_d = 1.
  - Required: illegal_e = 1, reg_write_e = 0, mem_write_e = 0, valid_e = 1.
- Counters (with `ID_EX_PERF_COUNT_EN`):
  - Stimulus: 4 flush cycles, then 2 stall cycles, then 1 stall+flush cycle.
  - Required: bubble_count = 5, stall_count = 2.

Source files
------------

// File: rtl/id_ex_pipeline_reg.sv
// rtl/id_ex_pipeline_reg.sv - ID/EX pipeline register with stall, flush and undefined-ALU-op trap
// Optional ID_EX_PERF_COUNT_EN adds saturating bubble/stall/illegal counters.

`ifndef ALU_OP_AND
`define ALU_OP_AND   3'b000
`define ALU_OP_OR    3'b001
`define ALU_OP_ADD   3'b010
`define ALU_OP_SLL   3'b011
`define ALU_OP_XOR   3'b100
`define ALU_OP_SRL   3'b101
`define ALU_OP_SUB   3'b110
`define ALU_OP_UNDEF 3'b111
`endif

module id_ex_pipeline_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_e,
    input  logic        flush_e,
    input  logic        valid_d,
    input  logic [2:0]  alu_op_d,
    input  logic        reg_write_d,
    input  logic        mem_to_reg_d,
    input  logic        mem_write_d,
    input  logic        mem_byte_d,
    input  logic        alu_src_d,
    input  logic        reg_dst_d,
    input  logic [31:0] rd1_d,
    input  logic [31:0] rd2_d,
    input  logic [31:0] sign_imm_d,
    input  logic [4:0]  rs_d,
    input  logic [4:0]  rt_d,
    input  logic [4:0]  rd_d,
    input  logic [4:0]  shamt_d,
`ifdef ID_EX_PERF_COUNT_EN
    output logic [31:0] bubble_count,
    output logic [31:0] stall_count,
    output logic [31:0] illegal_count,
`endif
    output logic        valid_e,
    output logic [2:0]  alu_op_e,
    output logic        reg_write_e,
    output logic        mem_to_reg_e,
    output logic        mem_write_e,
    output logic        mem_byte_e,
    output logic        alu_src_e,
    output logic        reg_dst_e,
    output logic [31:0] rd1_e,
    output logic [31:0] rd2_e,
    output logic [31:0] sign_imm_e,
    output logic [4:0]  rs_e,
    output logic [4:0]  rt_e,
    output logic [4:0]  rd_e,
    output logic [4:0]  shamt_e,
    output logic        illegal_e
);

    logic illegal_d;
    logic load_bubble;
    logic load_word;

    assign illegal_d   = valid_d & (alu_op_d == `ALU_OP_UNDEF);
    assign load_bubble = rst | flush_e;
    assign load_word   = ~rst & ~flush_e & ~stall_e;

    always_ff @(posedge clk) begin
        if (load_bubble) begin
            // Zeroed rs/rt keep the forwarding unit from matching a bubble.
            valid_e      <= 1'b0;
            alu_op_e     <= `ALU_OP_ADD;
            reg_write_e  <= 1'b0;
            mem_to_reg_e <= 1'b0;
            mem_write_e  <= 1'b0;
            mem_byte_e   <= 1'b0;
            alu_src_e    <= 1'b0;
            reg_dst_e    <= 1'b0;
            rd1_e        <= 32'd0;
            rd2_e        <= 32'd0;
            sign_imm_e   <= 32'd0;
            rs_e         <= 5'd0;
            rt_e         <= 5'd0;
            rd_e         <= 5'd0;
            shamt_e      <= 5'd0;
            illegal_e    <= 1'b0;
        end else if (load_word) begin
            // A trapped op must not commit architectural state.
            valid_e      <= valid_d;
            alu_op_e     <= alu_op_d;
            reg_write_e  <= reg_write_d & ~illegal_d;
            mem_to_reg_e <= mem_to_reg_d & ~illegal_d;
            mem_write_e  <= mem_write_d & ~illegal_d;
            mem_byte_e   <= mem_byte_d;
            alu_src_e    <= alu_src_d;
            reg_dst_e    <= reg_dst_d;
            rd1_e        <= rd1_d;
            rd2_e        <= rd2_d;
            sign_imm_e   <= sign_imm_d;
            rs_e         <= rs_d;
            rt_e         <= rt_d;
            rd_e         <= rd_d;
            shamt_e      <= shamt_d;
            illegal_e    <= illegal_d;
        end
    end

`ifdef ID_EX_PERF_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_count  <= 32'd0;
            stall_count   <= 32'd0;
            illegal_count <= 32'd0;
        end else begin
            if (flush_e && bubble_count != 32'hFFFF_FFFF)
                bubble_count <= bubble_count + 32'd1;
            if (stall_e && !flush_e && stall_count != 32'hFFFF_FFFF)
                stall_count <= stall_count + 32'd1;
            if (load_word && illegal_d && illegal_count != 32'hFFFF_FFFF)
                illegal_count <= illegal_count + 32'd1;
        end
    end
`endif

endmodule
